// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM state type for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int          WORD_WIDTH        = 32;
  localparam logic [31:0] BOOT_ADDRESS      = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTRUCTION   = 32'h0000_0000;
  localparam logic [31:0] INSTRUCTION_BYTES = 32'd4;

  typedef enum logic [1:0] {
    FETCH_S = 2'd0,
    HOLD_S  = 2'd1,
    DRAIN_S = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_skid_buffer.sv
// One-entry skid buffer that catches an instruction returned while decode is stalled.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  unload,
  input  logic                  flush,
  input  logic [WORD_WIDTH-1:0] load_instr,
  input  logic [WORD_WIDTH-1:0] load_pc,
  output logic                  valid,
  output logic [WORD_WIDTH-1:0] instr,
  output logic [WORD_WIDTH-1:0] pc
);

  // Flush wins over load so a redirect always empties the entry; unload just clears valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= NOP_INSTRUCTION;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, talks to the icache over req/ready,
// and feeds one instruction per cycle to decode with stall and branch handling.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  branch_taken_in,
  input  logic [WORD_WIDTH-1:0] branch_target_in,
  output logic                  icache_req_out,
  output logic [WORD_WIDTH-1:0] icache_addr_out,
  input  logic                  icache_ready_in,
  input  logic [WORD_WIDTH-1:0] icache_data_in,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic                  valid_out
);

  fetch_state_e          state;
  fetch_state_e          next_state;
  logic [WORD_WIDTH-1:0] fetch_pc;
  logic [WORD_WIDTH-1:0] drain_addr;
  logic                  transfer;
  logic                  skid_load;
  logic                  skid_unload;
  logic                  skid_valid;
  logic [WORD_WIDTH-1:0] skid_instr;
  logic [WORD_WIDTH-1:0] skid_pc;

  assign transfer    = icache_req_out && icache_ready_in;
  assign skid_load   = !branch_taken_in && (state == FETCH_S) && transfer && stall_in;
  assign skid_unload = !branch_taken_in && (state == HOLD_S) && !stall_in;

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .unload     (skid_unload),
    .flush      (branch_taken_in),
    .load_instr (icache_data_in),
    .load_pc    (fetch_pc),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_S;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a redirect with a pending unanswered request must drain it first.
  always_comb begin
    next_state = state;
    if (branch_taken_in) begin
      next_state = (icache_req_out && !icache_ready_in) ? DRAIN_S : FETCH_S;
    end else begin
      case (state)
        FETCH_S: if (transfer && stall_in) next_state = HOLD_S;
        HOLD_S:  if (!stall_in) next_state = FETCH_S;
        DRAIN_S: if (icache_ready_in) next_state = FETCH_S;
        default: next_state = FETCH_S;
      endcase
    end
  end

  // Request outputs depend on registered state only; DRAIN keeps the stale address stable.
  always_comb begin
    icache_req_out  = 1'b1;
    icache_addr_out = fetch_pc;
    case (state)
      HOLD_S:  icache_req_out = 1'b0;
      DRAIN_S: icache_addr_out = drain_addr;
      default: icache_req_out = 1'b1;
    endcase
  end

  // Fetch PC, drain address and the decode-facing output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc        <= BOOT_ADDRESS;
      drain_addr      <= BOOT_ADDRESS;
      valid_out       <= 1'b0;
      instruction_out <= NOP_INSTRUCTION;
      pc_out          <= '0;
    end else if (branch_taken_in) begin
      valid_out       <= 1'b0;
      instruction_out <= NOP_INSTRUCTION;
      fetch_pc        <= branch_target_in;
      if (icache_req_out && !icache_ready_in) begin
        drain_addr <= icache_addr_out;
      end
    end else begin
      case (state)
        FETCH_S: begin
          if (transfer) begin
            fetch_pc <= fetch_pc + INSTRUCTION_BYTES;
            if (!stall_in) begin
              valid_out       <= 1'b1;
              instruction_out <= icache_data_in;
              pc_out          <= fetch_pc;
            end
          end else if (!stall_in) begin
            valid_out       <= 1'b0;
            instruction_out <= NOP_INSTRUCTION;
          end
        end
        HOLD_S: begin
          if (!stall_in) begin
            valid_out       <= skid_valid;
            instruction_out <= skid_instr;
            pc_out          <= skid_pc;
          end
        end
        DRAIN_S: begin
          if (!stall_in) begin
            valid_out       <= 1'b0;
            instruction_out <= NOP_INSTRUCTION;
          end
        end
        default: begin
          valid_out       <= 1'b0;
          instruction_out <= NOP_INSTRUCTION;
        end
      endcase
    end
  end

endmodule
